// File: rtl/aibcr3_str_iodrv_if.sv
// Burst handshake between link-training logic and the strobe driver.
//   burst_req  : level request from the sequencer
//   burst_len  : number of full strobe periods in the requested burst
//   burst_ack  : one-cycle pulse when the driver accepts a request
//   burst_done : one-cycle pulse when a burst ends normally
//   busy       : burst in progress
// master = sequencer side, slave = driver side.
interface aibcr3_str_iodrv_if #(
  parameter int CNT_W = 8
) ();
  logic             burst_req;
  logic [CNT_W-1:0] burst_len;
  logic             burst_ack;
  logic             burst_done;
  logic             busy;

  modport master (
    output burst_req, burst_len,
    input  burst_ack, burst_done, busy
  );

  modport slave (
    input  burst_req, burst_len,
    output burst_ack, burst_done, busy
  );
endinterface

// File: rtl/aibcr3_str_iodrv.sv
// Forwarded-strobe transmit driver. Holds a programmable idle level and, on
// request, emits a burst of full strobe periods framed by a half-period lead
// and a half-period tail at the idle level. Half-period H = 2^cfg_div clocks.
// Ports:
//   clk, rstb    : core clock, synchronous active-low reset
//   cfg_en       : driver enable; low tristates the pad and aborts a burst
//   cfg_div      : half-period exponent (H = 1..128)
//   cfg_idle_lvl : strobe level outside toggling
//   bus          : burst req/len/ack/done/busy handshake (slave side)
//   str_out      : strobe data to pad driver
//   str_oe       : pad output enable
//
// state | meaning
// IDLE  | str_out/str_oe track cfg, wait for an enabled request
// LEAD  | hold latched idle level for H cycles
// RUN   | invert str_out every H cycles, 2L toggles in total
// TAIL  | hold idle level for H cycles, then pulse done
module aibcr3_str_iodrv #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 cfg_en,
  input  logic [2:0]           cfg_div,
  input  logic                 cfg_idle_lvl,
  aibcr3_str_iodrv_if.slave    bus,
  output logic                 str_out,
  output logic                 str_oe
);

  typedef enum logic [1:0] {IDLE, LEAD, RUN, TAIL} state_t;

  state_t           state, state_nxt;
  logic [6:0]       hcnt, hcnt_nxt;
  logic [CNT_W:0]   tcnt, tcnt_nxt;
  logic [2:0]       div_lat, div_nxt;
  logic             idle_lat, idle_nxt;
  logic [CNT_W-1:0] len_lat, len_nxt;
  logic             ack_q, ack_nxt;
  logic             done_q, done_nxt;
  logic             busy_q, busy_nxt;
  logic             out_q, out_nxt;
  logic             oe_q, oe_nxt;

  // Terminal count of the half-period counter is H-1 (0..127).
  logic [7:0]       h_full, h_m1;
  logic [6:0]       hterm;
  logic             h_end;
  logic [CNT_W:0]   tcnt_inc;
  logic [CNT_W:0]   len2;

  assign h_full   = 8'd1 << div_lat;
  assign h_m1     = h_full - 8'd1;
  assign hterm    = h_m1[6:0];
  assign h_end    = (hcnt == hterm);
  assign tcnt_inc = tcnt + {{CNT_W{1'b0}}, 1'b1};
  assign len2     = {len_lat, 1'b0};

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= IDLE;
      hcnt     <= '0;
      tcnt     <= '0;
      div_lat  <= '0;
      idle_lat <= 1'b0;
      len_lat  <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hcnt     <= hcnt_nxt;
      tcnt     <= tcnt_nxt;
      div_lat  <= div_nxt;
      idle_lat <= idle_nxt;
      len_lat  <= len_nxt;
      ack_q    <= ack_nxt;
      done_q   <= done_nxt;
      busy_q   <= busy_nxt;
      out_q    <= out_nxt;
      oe_q     <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    tcnt_nxt  = tcnt;
    div_nxt   = div_lat;
    idle_nxt  = idle_lat;
    len_nxt   = len_lat;
    ack_nxt   = 1'b0;
    done_nxt  = 1'b0;
    busy_nxt  = busy_q;
    out_nxt   = out_q;
    oe_nxt    = oe_q;

    case (state)
      IDLE: begin
        oe_nxt   = cfg_en;
        out_nxt  = cfg_idle_lvl;
        busy_nxt = 1'b0;
        if (cfg_en && bus.burst_req) begin
          div_nxt  = cfg_div;
          idle_nxt = cfg_idle_lvl;
          len_nxt  = bus.burst_len;
          ack_nxt  = 1'b1;
          hcnt_nxt = '0;
          tcnt_nxt = '0;
          // A zero-length burst completes immediately without leaving IDLE.
          if (bus.burst_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = LEAD;
            busy_nxt  = 1'b1;
          end
        end
      end
      LEAD: begin
        if (h_end) begin
          // Entry into RUN carries the first toggle.
          out_nxt   = ~idle_lat;
          tcnt_nxt  = {{CNT_W{1'b0}}, 1'b1};
          hcnt_nxt  = '0;
          state_nxt = RUN;
        end else begin
          hcnt_nxt = hcnt + 7'd1;
        end
      end
      RUN: begin
        if (h_end) begin
          out_nxt  = ~out_q;
          tcnt_nxt = tcnt_inc;
          hcnt_nxt = '0;
          if (tcnt_inc == len2) state_nxt = TAIL;
        end else begin
          hcnt_nxt = hcnt + 7'd1;
        end
      end
      TAIL: begin
        if (h_end) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          out_nxt   = idle_lat;
          hcnt_nxt  = '0;
          tcnt_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt + 7'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Disable overrides any in-flight burst: park at idle, tristate, no done.
    if (state != IDLE && !cfg_en) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      out_nxt   = idle_lat;
      done_nxt  = 1'b0;
      hcnt_nxt  = '0;
      tcnt_nxt  = '0;
    end
  end

  assign bus.burst_ack  = ack_q;
  assign bus.burst_done = done_q;
  assign bus.busy       = busy_q;
  assign str_out        = out_q;
  assign str_oe         = oe_q;

endmodule

// File: tb/tb_aibcr3_str_iodrv.sv
// Directed bench for aibcr3_str_iodrv. Inputs change and outputs are
// observed at the falling edge; "cycle c" is the interval whose falling edge
// is the c-th after the request cycle. Observed vector = {ack,done,busy,out,oe}.
module tb_aibcr3_str_iodrv;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rstb;
  logic       cfg_en;
  logic [2:0] cfg_div;
  logic       cfg_idle_lvl;
  logic       str_out;
  logic       str_oe;

  int total = 0;
  int bad   = 0;

  aibcr3_str_iodrv_if #(.CNT_W(CNT_W)) bus ();

  aibcr3_str_iodrv #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .cfg_en       (cfg_en),
    .cfg_div      (cfg_div),
    .cfg_idle_lvl (cfg_idle_lvl),
    .bus          (bus),
    .str_out      (str_out),
    .str_oe       (str_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {bus.burst_ack, bus.burst_done, bus.busy, str_out, str_oe};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Expected {ack,done,busy,out,oe} for cycles 1..N of each directed case.
  logic [4:0] exp_min [6] = '{5'b10101, 5'b00111, 5'b00101, 5'b00111, 5'b00101, 5'b01001};
  logic [4:0] exp_div [8] = '{5'b10111, 5'b00111, 5'b00101, 5'b00101,
                              5'b00111, 5'b00111, 5'b01011, 5'b00001};
  logic [4:0] exp_abt [9] = '{5'b10101, 5'b00101, 5'b00101, 5'b00101,
                              5'b00111, 5'b00111, 5'b00000, 5'b00000, 5'b10101};
  logic [4:0] exp_b2b [9] = '{5'b10101, 5'b00111, 5'b00101, 5'b01001,
                              5'b10101, 5'b00111, 5'b00101, 5'b01001, 5'b00001};

  int   done_at;
  int   toggles;
  int   extra_ack;
  logic prev;

  initial begin
    // Reset with random inputs
    rstb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_en        = 1'($urandom);
      cfg_div       = 3'($urandom);
      cfg_idle_lvl  = 1'($urandom);
      bus.burst_req = 1'($urandom);
      bus.burst_len = 8'($urandom);
      cyc();
      chk($sformatf("reset_%0d", i), 32'(outs()), 32'd0);
    end
    cfg_en = 1'b0; cfg_div = 3'd0; cfg_idle_lvl = 1'b0;
    bus.burst_req = 1'b0; bus.burst_len = '0;
    rstb = 1'b1;
    #1;
    chk("release_c0", 32'(outs()), 32'd0);
    cyc();
    chk("release_c1", 32'(outs()), 32'd0);

    // Minimum burst: div=0 idle=0 L=2
    cfg_en = 1'b1; cfg_div = 3'd0; cfg_idle_lvl = 1'b0;
    bus.burst_len = 8'd2; bus.burst_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      chk($sformatf("min_c%0d", c), 32'(outs()), 32'(exp_min[c-1]));
      if (c == 1) bus.burst_req = 1'b0;
    end

    // Divided burst: div=1 idle=1 L=1, config disturbed at cycle 2
    cfg_div = 3'd1; cfg_idle_lvl = 1'b1; bus.burst_len = 8'd1; bus.burst_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk($sformatf("div_c%0d", c), 32'(outs()), 32'(exp_div[c-1]));
      if (c == 1) bus.burst_req = 1'b0;
      if (c == 2) begin cfg_div = 3'd0; cfg_idle_lvl = 1'b0; end
    end

    // Zero-length burst
    cfg_idle_lvl = 1'b1; bus.burst_len = 8'd0; bus.burst_req = 1'b1;
    cyc();
    chk("len0_c1", 32'(outs()), 32'(5'b11011));
    bus.burst_req = 1'b0;
    cyc();
    chk("len0_c2", 32'(outs()), 32'(5'b00011));
    cfg_idle_lvl = 1'b0;
    cyc();
    chk("len0_c3", 32'(outs()), 32'(5'b00001));

    // Abort: div=2 L=4, cfg_en low in cycle 6-7, req held high throughout
    cfg_div = 3'd2; bus.burst_len = 8'd4; bus.burst_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      chk($sformatf("abort_c%0d", c), 32'(outs()), 32'(exp_abt[c-1]));
      if (c == 6) cfg_en = 1'b0;
      if (c == 8) cfg_en = 1'b1;
    end
    bus.burst_req = 1'b0;
    done_at = 0; extra_ack = 0;
    for (int i = 10; i <= 60 && done_at == 0; i++) begin
      cyc();
      if (bus.burst_ack) extra_ack++;
      if (bus.burst_done) done_at = i;
    end
    chk("abort_rerun_done_cycle", 32'(done_at), 32'd45);
    chk("abort_rerun_extra_ack", 32'(extra_ack), 32'd0);

    // Back-to-back: req held high, div=0 L=1
    cfg_div = 3'd0; cfg_idle_lvl = 1'b0; bus.burst_len = 8'd1; bus.burst_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      chk($sformatf("b2b_c%0d", c), 32'(outs()), 32'(exp_b2b[c-1]));
      if (c == 7) bus.burst_req = 1'b0;
    end

    // Longest burst: L=255 div=7 idle=1
    cfg_div = 3'd7; cfg_idle_lvl = 1'b1; bus.burst_len = 8'd255; bus.burst_req = 1'b1;
    cyc();
    chk("long_c1", 32'(outs()), 32'(5'b10111));
    bus.burst_req = 1'b0;
    prev = str_out; done_at = 0; toggles = 0;
    for (int i = 2; i <= 70000 && done_at == 0; i++) begin
      cyc();
      if (str_out !== prev) toggles++;
      prev = str_out;
      if (bus.burst_done) done_at = i;
    end
    chk("long_done_cycle", 32'(done_at), 32'd65409);
    chk("long_toggles", 32'(toggles), 32'd510);
    chk("long_done_outs", 32'(outs()), 32'(5'b01011));

    // Reset mid-burst: div=0 idle=1 L=2, rstb low in cycle 2
    cfg_div = 3'd0; cfg_idle_lvl = 1'b1; bus.burst_len = 8'd2; bus.burst_req = 1'b1;
    cyc();
    chk("midrst_c1", 32'(outs()), 32'(5'b10111));
    bus.burst_req = 1'b0;
    cyc();
    chk("midrst_c2", 32'(outs()), 32'(5'b00101));
    rstb = 1'b0;
    cyc();
    chk("midrst_c3", 32'(outs()), 32'd0);
    rstb = 1'b1;
    cyc();
    chk("midrst_c4", 32'(outs()), 32'(5'b00011));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aibcr3_str_iodrv.md
# aibcr3_str_iodrv

Strobe driver for the AIB forwarded-strobe path: the transmit end that drives the strobe pad which the far side terminates with its strobe IO load. It holds a programmable idle level, then on request emits a burst of full strobe periods. Each burst is framed by a one-half-period lead and a one-half-period tail at the idle level. Half-period length is a power of two of the core clock. A req/ack handshake starts each burst and a done pulse ends it, so link-training logic can sequence strobe bursts.

## Interface
Parameters:
- CNT_W, 8, width of burst_len (max burst = 2^CNT_W-1 periods)

Ports:
- clk  input  1  core clock; all logic on rising edge
- rstb  input  1  reset, synchronous, active-low
- cfg_en  input  1  driver enable; 0 tristates the strobe and aborts any burst
- cfg_div  input  3  half-period H = 2^cfg_div clk cycles (1..128)
- cfg_idle_lvl  input  1  strobe level outside toggling
- burst_req  input  1  burst request, level, sampled when not busy
- burst_len  input  CNT_W  number of full strobe periods L
- burst_ack  output  1  one-cycle pulse: request accepted
- burst_done  output  1  one-cycle pulse: burst completed normally
- busy  output  1  burst in progress
- str_out  output  1  strobe data to pad driver
- str_oe  output  1  pad output enable

## Operation
- All outputs are registered. Reset values: str_out=0, str_oe=0, burst_ack=0, burst_done=0, busy=0; state=IDLE; all counters 0.
- States: IDLE, LEAD, RUN, TAIL.
- IDLE:
  - str_oe=cfg_en; str_out=cfg_idle_lvl, tracking each cycle.
  - If cfg_en=1 and burst_req=1, the request is accepted.
  - On acceptance, cfg_div, cfg_idle_lvl and burst_len are latched; later changes are ignored until the next IDLE.
  - burst_len=0: burst_ack and burst_done both pulse in the same next cycle; state stays IDLE; no toggles.
  - burst_len≠0: go to LEAD; burst_ack=1 and busy=1 next cycle.
- LEAD: holds the latched idle level for H cycles, then enters RUN.
- RUN:
  - On entry and every H cycles after, str_out inverts, for exactly 2L toggles.
  - The first toggle drives ~idle; after the last toggle, str_out is back at idle.
  - After the last toggle, go to TAIL.
- TAIL: holds idle for H cycles, then pulses burst_done for one cycle with busy=0; returns to IDLE.
- burst_req while busy=1 is ignored; there is no queueing. A level still high at burst_done is accepted as a new burst.
- Abort: cfg_en=0 in any non-IDLE state gives, next cycle: IDLE, str_oe=0, busy=0, str_out=latched idle, no burst_done.
- Counters:
  - half-period counter: 7 bits, counts 0..H-1, wraps.
  - toggle counter: CNT_W+1 bits, counts to 2L with no overflow.
- rstb=0 mid-burst: all outputs return to reset values at the next edge; no done pulse.

## Timing
- Cycle 0 = the cycle in which burst_req is sampled high with busy=0 and cfg_en=1.
- burst_ack and busy are high in cycle 1.
- Toggles are visible at cycles 1+H+k·H, for k=0..2L-1. The last toggle is at cycle 1+2LH.
- burst_done is high in cycle 1+(2L+1)H; busy is low in the same cycle.
- Total busy duration is (2L+1)H cycles.
- cfg_en to str_oe latency: 1 cycle.
- In IDLE, cfg_idle_lvl to str_out latency: 1 cycle.

## Test plan
- Reset: hold rstb=0 for 3 cycles with random inputs.
  - Required: all outputs 0 throughout and for the first cycle after release.
- Minimum burst: cfg_en=1, div=0, idle=0, L=2, req in cycle 0.
  - Required: ack@1; str_out=1,0,1,0 at cycles 2,3,4,5; done@6; busy high 1–5.
- Divided burst: div=1, idle=1, L=1.
  - Required: str_out 0@3, 1@5; done@7.
  - A change of cfg_div to 0 and idle to 0 at cycle 2 has no effect on this burst.
- Edge lengths:
  - L=0: ack and done together at cycle 1; busy stays 0; str_out stays idle.
  - L=255 with div=7: done at cycle 1+511·128 = 65409.
- Abort: div=2, L=4; drop cfg_en at cycle 6.
  - Required: cycle 7 has str_oe=0, busy=0, str_out=idle, no burst_done.
  - Re-enable with req held high: new ack one cycle after cfg_en rises.
- Back-to-back: req held high, div=0, L=1.
  - Required: done@4; second ack@5; requests made while busy produce no extra ack.
